bit_serializer4: RTL and testbench

BIT_SERIALIZER4 -- requirements
Module: bit_serializer4

---
 rtl/bit_serializer4.sv | 142 ++++++++++++++
 tb/tb_bit_serializer4.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer4.sv
// bit_serializer4: accepts a 4-bit word over a valid/ready handshake and
// emits it one bit per beat over a second valid/ready handshake.
// MSB_FIRST selects the bit order (0: bit 0 first, 1: bit 3 first).
// Optional macro BIT_SERIALIZER4_PRELOAD_EN adds a one-word preload buffer
// so consecutive words stream without an idle cycle between them.
module bit_serializer4 #(
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] x_hold,
    output logic [1:0] out_sel,
    output logic       out_bit,
    output logic       out_last
);

    localparam logic [1:0] START_IDX = (MSB_FIRST != 0) ? 2'd3 : 2'd0;
    localparam logic [1:0] LAST_IDX  = (MSB_FIRST != 0) ? 2'd0 : 2'd3;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t     state, state_n;
    logic [3:0] x_hold_n;
    logic [1:0] sel_n;
    logic [1:0] sel_step;
    logic       transfer;
    logic       beat;
    logic       last_beat;

`ifdef BIT_SERIALIZER4_PRELOAD_EN
    logic [3:0] pre_buf, pre_buf_n;
    logic       pre_full, pre_full_n;
`endif

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: active word, beat select and optional preload buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            x_hold  <= '0;
            out_sel <= START_IDX;
`ifdef BIT_SERIALIZER4_PRELOAD_EN
            pre_buf  <= '0;
            pre_full <= 1'b0;
`endif
        end else begin
            x_hold  <= x_hold_n;
            out_sel <= sel_n;
`ifdef BIT_SERIALIZER4_PRELOAD_EN
            pre_buf  <= pre_buf_n;
            pre_full <= pre_full_n;
`endif
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_n  = state;
        x_hold_n = x_hold;
        sel_n    = out_sel;
`ifdef BIT_SERIALIZER4_PRELOAD_EN
        pre_buf_n  = pre_buf;
        pre_full_n = pre_full;
`endif
        case (state)
            IDLE: begin
                if (transfer) begin
                    x_hold_n = in_data;
                    sel_n    = START_IDX;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
`ifdef BIT_SERIALIZER4_PRELOAD_EN
                if (last_beat) begin
                    sel_n = START_IDX;
                    // Buffered word takes priority; in_ready is low while it is full,
                    // so a same-cycle transfer can only happen with the buffer empty.
                    if (pre_full) begin
                        x_hold_n   = pre_buf;
                        pre_full_n = 1'b0;
                    end else if (transfer) begin
                        x_hold_n = in_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (beat) begin
                        sel_n = sel_step;
                    end
                    if (transfer) begin
                        pre_buf_n  = in_data;
                        pre_full_n = 1'b1;
                    end
                end
`else
                if (last_beat) begin
                    sel_n   = START_IDX;
                    state_n = IDLE;
                end else if (beat) begin
                    sel_n = sel_step;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Handshake and serial outputs
    always_comb begin
        out_valid = (state == SHIFT);
        out_last  = out_valid && (out_sel == LAST_IDX);
        out_bit   = x_hold[out_sel];
        sel_step  = (MSB_FIRST != 0) ? (out_sel - 2'd1) : (out_sel + 2'd1);
`ifdef BIT_SERIALIZER4_PRELOAD_EN
        in_ready  = !pre_full && !reset;
`else
        in_ready  = (state == IDLE) && !reset;
`endif
        transfer  = in_valid && in_ready;
        beat      = out_valid && out_ready;
        last_beat = beat && out_last;
    end

endmodule

// File: tb/tb_bit_serializer4.sv
// Self-checking bench for bit_serializer4: per-cycle vector table for
// LSB-first behaviour, plus hand-written sequences for MSB-first order and
// back-to-back streaming (expectations follow BIT_SERIALIZER4_PRELOAD_EN).
module tb_bit_serializer4;

`ifdef BIT_SERIALIZER4_PRELOAD_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_bit0, out_last0;
    logic [3:0] x_hold0;
    logic [1:0] out_sel0;
    logic       in_ready1, out_valid1, out_bit1, out_last1;
    logic [3:0] x_hold1;
    logic [1:0] out_sel1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serializer4 #(.MSB_FIRST(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
        .x_hold(x_hold0), .out_sel(out_sel0), .out_bit(out_bit0), .out_last(out_last0)
    );

    bit_serializer4 #(.MSB_FIRST(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
        .x_hold(x_hold1), .out_sel(out_sel1), .out_bit(out_bit1), .out_last(out_last1)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [1:0] e_sel;
        logic       e_bit;
        logic       e_last;
        logic [3:0] e_xh;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [3:0] d,
                                input logic ordy, input logic e_ir, input logic e_ov,
                                input logic [1:0] e_sel, input logic e_bit,
                                input logic e_last, input logic [3:0] e_xh);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_sel = e_sel;
        v.e_bit = e_bit; v.e_last = e_last; v.e_xh = e_xh;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [3:0] d, input logic ordy);
        @(posedge clk);
        #1;
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        logic [0:15] eov;
        logic [0:15] eir;
        logic [3:0]  words[3];
        logic        ebit;
        int          idx;
        int          nbeat;
        int          dut_beats;

        reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;

        //             rst iv  d      rdy  ir  ov  sel   bit last xh
        // Reset, then word 1010 with data changing after the transfer
        tbl[0]  = mk(1, 0, 4'b0000, 1, 0, 0, 2'd0, 0, 0, 4'b0000);
        tbl[1]  = mk(0, 1, 4'b1010, 1, 1, 0, 2'd0, 0, 0, 4'b0000);
        tbl[2]  = mk(0, 0, 4'b0000, 1, 0, 1, 2'd0, 0, 0, 4'b1010);
        tbl[3]  = mk(0, 0, 4'b0000, 1, 0, 1, 2'd1, 1, 0, 4'b1010);
        tbl[4]  = mk(0, 0, 4'b0000, 1, 0, 1, 2'd2, 0, 0, 4'b1010);
        tbl[5]  = mk(0, 0, 4'b0000, 1, 0, 1, 2'd3, 1, 1, 4'b1010);
        tbl[6]  = mk(0, 0, 4'b0000, 1, 1, 0, 2'd0, 0, 0, 4'b1010);
        // Word 0110 with a 3-cycle stall on beat 2
        tbl[7]  = mk(0, 1, 4'b0110, 1, 1, 0, 2'd0, 0, 0, 4'b1010);
        tbl[8]  = mk(0, 0, 4'b1111, 1, 0, 1, 2'd0, 0, 0, 4'b0110);
        tbl[9]  = mk(0, 0, 4'b1111, 0, 0, 1, 2'd1, 1, 0, 4'b0110);
        tbl[10] = mk(0, 0, 4'b1111, 0, 0, 1, 2'd1, 1, 0, 4'b0110);
        tbl[11] = mk(0, 0, 4'b1111, 0, 0, 1, 2'd1, 1, 0, 4'b0110);
        tbl[12] = mk(0, 0, 4'b1111, 1, 0, 1, 2'd1, 1, 0, 4'b0110);
        tbl[13] = mk(0, 0, 4'b1111, 1, 0, 1, 2'd2, 1, 0, 4'b0110);
        tbl[14] = mk(0, 0, 4'b1111, 1, 0, 1, 2'd3, 0, 1, 4'b0110);
        tbl[15] = mk(0, 0, 4'b1111, 1, 1, 0, 2'd0, 0, 0, 4'b0110);
        // Word 1111 abandoned by reset on beat 2, then word 0001
        tbl[16] = mk(0, 1, 4'b1111, 1, 1, 0, 2'd0, 0, 0, 4'b0110);
        tbl[17] = mk(0, 0, 4'b0000, 1, 0, 1, 2'd0, 1, 0, 4'b1111);
        tbl[18] = mk(1, 0, 4'b0000, 1, 0, 1, 2'd1, 1, 0, 4'b1111);
        tbl[19] = mk(0, 0, 4'b0000, 1, 1, 0, 2'd0, 0, 0, 4'b0000);
        tbl[20] = mk(0, 1, 4'b0001, 1, 1, 0, 2'd0, 0, 0, 4'b0000);
        tbl[21] = mk(0, 0, 4'b0000, 1, 0, 1, 2'd0, 1, 0, 4'b0001);
        tbl[22] = mk(0, 0, 4'b0000, 1, 0, 1, 2'd1, 0, 0, 4'b0001);
        tbl[23] = mk(0, 0, 4'b0000, 1, 0, 1, 2'd2, 0, 0, 4'b0001);
        tbl[24] = mk(0, 0, 4'b0000, 1, 0, 1, 2'd3, 0, 1, 4'b0001);
        tbl[25] = mk(0, 0, 4'b0000, 1, 1, 0, 2'd0, 1, 0, 4'b0001);

        // The first edge happens with reset high, so row 0 sees reset state.
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            // The buffer never fills in the table, so with preload in_ready is just !reset.
            check($sformatf("row%0d in_ready", i), int'(in_ready0),
                  PRE ? int'(!tbl[i].rst) : int'(tbl[i].e_ir));
            check($sformatf("row%0d out_valid", i), int'(out_valid0), int'(tbl[i].e_ov));
            check($sformatf("row%0d out_sel", i), int'(out_sel0), int'(tbl[i].e_sel));
            check($sformatf("row%0d out_bit", i), int'(out_bit0), int'(tbl[i].e_bit));
            check($sformatf("row%0d out_last", i), int'(out_last0), int'(tbl[i].e_last));
            check($sformatf("row%0d x_hold", i), int'(x_hold0), int'(tbl[i].e_xh));
        end

        // MSB-first instance: reset state, then word 1100
        drive(1, 0, 4'h0, 1);
        drive(1, 0, 4'h0, 1);
        check("msb reset out_sel", int'(out_sel1), 3);
        check("msb reset out_valid", int'(out_valid1), 0);
        check("msb reset out_last", int'(out_last1), 0);
        check("msb reset out_bit", int'(out_bit1), 0);
        check("msb reset in_ready", int'(in_ready1), 0);
        drive(0, 1, 4'b1100, 1);
        check("msb idle in_ready", int'(in_ready1), 1);
        for (int b = 0; b < 4; b++) begin
            drive(0, 0, 4'h0, 1);
            check($sformatf("msb beat%0d out_valid", b), int'(out_valid1), 1);
            check($sformatf("msb beat%0d out_sel", b), int'(out_sel1), 3 - b);
            check($sformatf("msb beat%0d out_bit", b), int'(out_bit1), (b < 2) ? 1 : 0);
            check($sformatf("msb beat%0d out_last", b), int'(out_last1), (b == 3) ? 1 : 0);
        end
        drive(0, 0, 4'h0, 1);
        check("msb end out_valid", int'(out_valid1), 0);
        check("msb end out_sel", int'(out_sel1), 3);
        check("msb end x_hold", int'(x_hold1), 4'b1100);

        // Back-to-back words A, 5, 3 with out_ready held high
        drive(1, 0, 4'h0, 1);
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h3;
        if (PRE) begin
            eov = 16'b0111_1111_1111_1000;
            eir = 16'b1100_0100_0111_1111;
        end else begin
            eov = 16'b0111_1011_1101_1110;
            eir = 16'b1000_0100_0010_0001;
        end
        idx = 0;
        nbeat = 0;
        dut_beats = 0;
        for (int c = 0; c < 16; c++) begin
            drive(0, idx < 3, (idx < 3) ? words[idx] : 4'h0, 1);
            check($sformatf("stream c%0d in_ready", c), int'(in_ready0), int'(eir[c]));
            check($sformatf("stream c%0d out_valid", c), int'(out_valid0), int'(eov[c]));
            check($sformatf("stream c%0d out_last", c), int'(out_last0),
                  int'(eov[c] && (nbeat % 4 == 3)));
            if (out_valid0) dut_beats++;
            if (eov[c] && nbeat < 12) begin
                ebit = words[nbeat / 4][nbeat % 4];
                check($sformatf("stream beat%0d out_bit", nbeat), int'(out_bit0), int'(ebit));
                nbeat++;
            end
            if (in_valid && eir[c]) idx++;
        end
        check("stream total beats", dut_beats, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
